adc_code_matcher: RTL and testbench
===================================

Name: adc_code_matcher

Overview:
- Downstream consumer of the SPI ADC front end's 10-bit conversion result and 3-bit channel select.
- Searches a 5-entry code table for the captured sample, from index 4 down to 0, one entry per clock.
- Returns the matching voltage and power entries, or a miss.
- Table entries are runtime-writable and reset to the standard calibration set.

Parameters:
- N_ENTRIES, 5: table depth; idx width is fixed at 3 bits, so N_ENTRIES must be at most 8.
- DW, 10: width of sample, code, voltage and power fields.
- TOL, 0: match tolerance; hit when the absolute difference |sample - code| <= TOL.
- CNT_W, 16: width of the hit counter.

Ports:
- fpga_clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- smp_valid  in  1  sample offered.
- smp_ready  out  1  block can accept a sample.
- smp_data  in  DW  ADC code, MSB-first result as assembled upstream.
- smp_chan  in  3  ADC channel the sample came from.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  3  table entry index.
- tbl_code  in  DW  code field to write.
- tbl_volt  in  DW  voltage field to write.
- tbl_power  in  DW  power field to write.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_hit  out  1  1 = match found, 0 = miss.
- res_idx  out  3  matching entry index (0 on miss).
- res_volt  out  DW  matched voltage (0 on miss).
- res_power  out  DW  matched power (0 on miss).
- res_chan  out  3  channel of the sample.
- hit_count  out  CNT_W  saturating count of hits since reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - smp_ready=1, res_valid=0, res_hit=0, res_idx=0, res_volt=0, res_power=0, res_chan=0, hit_count=0.
  - Table reloads defaults, listed as idx: code/volt/power:
    - 0: 1023/5/45
    - 1: 819/4/50
    - 2: 614/3/75
    - 3: 409/2/80
    - 4: 204/1/20
  - Asserting reset mid-SEARCH or mid-HOLD drops the pending result. No partial output is produced.
- States: IDLE, SEARCH, HOLD.
- IDLE:
  - smp_ready=1.
  - When smp_valid && smp_ready on an edge (E0): latch smp_data and smp_chan, set idx=N_ENTRIES-1, go to SEARCH.
- SEARCH:
  - smp_ready=0.
  - Each cycle compare the latched sample with code[idx]. The absolute difference is computed in DW+1 bits, unsigned.
  - Hit: load res_* from entry idx, set res_hit=1, increment hit_count (saturating at all-ones), go to HOLD.
  - Miss with idx>0: decrement idx and stay in SEARCH.
  - Miss with idx==0: res_hit=0, res_idx=0, res_volt=0, res_power=0, res_chan=latched channel, go to HOLD.
  - The first match in descending index order wins.
- Latency:
  - Hit at index j: res_valid rises after edge E(N_ENTRIES-j). Example: j=4 gives 1 edge after acceptance.
  - Miss: res_valid rises after edge E(N_ENTRIES).
- HOLD:
  - res_valid=1 and smp_ready=0.
  - All res_* outputs are stable until res_valid && res_ready on an edge.
  - On that edge: res_valid=0, go to IDLE, smp_ready=1 on the next cycle. No same-cycle turnaround.
  - smp_valid is ignored while not in IDLE. The upstream stage holds its sample.
- Table writes:
  - Accepted in any state. A write with tbl_addr >= N_ENTRIES is ignored.
  - The new value is visible from the edge after the write.
  - If the same entry is compared in the write cycle, the comparison uses the old value.
- Result registers change only on the SEARCH->HOLD transition and on reset.

Decomposition:
- Package adc_match_pkg holds:
  - N_ENTRIES and DW.
  - Default code, voltage and power constant arrays.
  - State enum {IDLE, SEARCH, HOLD}.
- Sub-module adc_code_table:
  - N_ENTRIES x (3 x DW) register file, asynchronous-reset to the package defaults.
  - One combinational read port addressed by idx, one synchronous write port.
- The top level holds the FSM, sample latch, comparator, result registers and hit counter.

Test Plan:
- Reset, TOL=0, accept sample 614 on channel 2 -> res_valid after 3 edges; hit=1, idx=2, volt=3, power=75, chan=2; hit_count=1.
- Sample 500 -> res_valid after 5 edges; hit=0, idx=0, volt=0, power=0; hit_count unchanged.
- TOL=4 instance: sample 1020 -> hit at idx 0, power 45. Sample 1018 -> miss. Sample 823 -> idx 1, power 50.
- Backpressure: hold res_ready=0 for 10 cycles while smp_valid=1 with a new sample -> res_* stable, smp_ready=0, no second acceptance. After the res_ready pulse, the new sample is accepted one cycle later.
- Write addr 1 with code 100, volt 7, power 99, then sample 100 -> hit idx 1, power 99. A write to addr 6 leaves the table unchanged (re-test sample 614 -> power 75).
- Assert rst_n low during SEARCH -> res_valid=0 and smp_ready=1 immediately; hit_count=0; entry 1 restored to 819/4/50.

Source files
------------

// File: rtl/adc_code_matcher_pkg.sv
// Shared constants, calibration defaults and FSM state type for the ADC code matcher.
package adc_match_pkg;

  localparam int N_ENTRIES   = 5;
  localparam int DW          = 10;
  localparam int MAX_ENTRIES = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    HOLD
  } state_e;

  // Standard calibration set; slots past N_ENTRIES are zero padding for the 3-bit index space.
  localparam logic [DW-1:0] DEF_CODE  [MAX_ENTRIES] = '{10'd1023, 10'd819, 10'd614, 10'd409,
                                                        10'd204, 10'd0, 10'd0, 10'd0};
  localparam logic [DW-1:0] DEF_VOLT  [MAX_ENTRIES] = '{10'd5, 10'd4, 10'd3, 10'd2,
                                                        10'd1, 10'd0, 10'd0, 10'd0};
  localparam logic [DW-1:0] DEF_POWER [MAX_ENTRIES] = '{10'd45, 10'd50, 10'd75, 10'd80,
                                                        10'd20, 10'd0, 10'd0, 10'd0};

endpackage

// File: rtl/adc_code_matcher_if.sv
// Sample, table-write and result channels of the ADC code matcher.
interface adc_code_matcher_if #(
  parameter int DW = adc_match_pkg::DW
);
  logic          smp_valid;
  logic          smp_ready;
  logic [DW-1:0] smp_data;
  logic [2:0]    smp_chan;

  logic          tbl_we;
  logic [2:0]    tbl_addr;
  logic [DW-1:0] tbl_code;
  logic [DW-1:0] tbl_volt;
  logic [DW-1:0] tbl_power;

  logic          res_valid;
  logic          res_ready;
  logic          res_hit;
  logic [2:0]    res_idx;
  logic [DW-1:0] res_volt;
  logic [DW-1:0] res_power;
  logic [2:0]    res_chan;

  modport master (
    output smp_valid, smp_data, smp_chan,
    output tbl_we, tbl_addr, tbl_code, tbl_volt, tbl_power,
    output res_ready,
    input  smp_ready,
    input  res_valid, res_hit, res_idx, res_volt, res_power, res_chan
  );

  modport slave (
    input  smp_valid, smp_data, smp_chan,
    input  tbl_we, tbl_addr, tbl_code, tbl_volt, tbl_power,
    input  res_ready,
    output smp_ready,
    output res_valid, res_hit, res_idx, res_volt, res_power, res_chan
  );
endinterface

// File: rtl/adc_code_matcher_table.sv
// Runtime-writable code/voltage/power table with one combinational read port.
module adc_code_table
  import adc_match_pkg::*;
#(
  parameter int N_ENTRIES = adc_match_pkg::N_ENTRIES,
  parameter int DW        = adc_match_pkg::DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [2:0]    waddr_i,
  input  logic [DW-1:0] wcode_i,
  input  logic [DW-1:0] wvolt_i,
  input  logic [DW-1:0] wpower_i,
  input  logic [2:0]    raddr_i,
  output logic [DW-1:0] code_o,
  output logic [DW-1:0] volt_o,
  output logic [DW-1:0] power_o
);

  logic [DW-1:0] code_q  [N_ENTRIES];
  logic [DW-1:0] volt_q  [N_ENTRIES];
  logic [DW-1:0] power_q [N_ENTRIES];

  // Per-entry decode: addresses at or beyond N_ENTRIES match no entry and are dropped.
  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        code_q[g]  <= DW'(DEF_CODE[g]);
        volt_q[g]  <= DW'(DEF_VOLT[g]);
        power_q[g] <= DW'(DEF_POWER[g]);
      end else if (we_i && (waddr_i == 3'(g))) begin
        code_q[g]  <= wcode_i;
        volt_q[g]  <= wvolt_i;
        power_q[g] <= wpower_i;
      end
    end
  end

  always_comb begin
    code_o  = '0;
    volt_o  = '0;
    power_o = '0;
    if (int'(raddr_i) < N_ENTRIES) begin
      code_o  = code_q[raddr_i];
      volt_o  = volt_q[raddr_i];
      power_o = power_q[raddr_i];
    end
  end

endmodule

// File: rtl/adc_code_matcher.sv
// Captures an ADC sample and scans the code table from the top index down, one entry per clock.
module adc_code_matcher
  import adc_match_pkg::*;
#(
  parameter int N_ENTRIES = adc_match_pkg::N_ENTRIES,
  parameter int DW        = adc_match_pkg::DW,
  parameter int TOL       = 0,
  parameter int CNT_W     = 16
) (
  input  logic             fpga_clk,
  input  logic             rst_n,
  adc_code_matcher_if.slave bus,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [DW:0] TOL_V = (DW+1)'(TOL);

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [DW-1:0]   smp_q, smp_d;
  logic [2:0]      chan_q, chan_d;
  logic            hit_q, hit_d;
  logic [2:0]      ridx_q, ridx_d;
  logic [DW-1:0]   volt_q, volt_d;
  logic [DW-1:0]   power_q, power_d;
  logic [2:0]      rchan_q, rchan_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DW-1:0] tcode, tvolt, tpower;
  logic [DW:0]   a_ext, b_ext, diff;
  logic          match;

  adc_code_table #(.N_ENTRIES(N_ENTRIES), .DW(DW)) u_table (
    .clk_i   (fpga_clk),
    .rst_ni  (rst_n),
    .we_i    (bus.tbl_we),
    .waddr_i (bus.tbl_addr),
    .wcode_i (bus.tbl_code),
    .wvolt_i (bus.tbl_volt),
    .wpower_i(bus.tbl_power),
    .raddr_i (idx_q),
    .code_o  (tcode),
    .volt_o  (tvolt),
    .power_o (tpower)
  );

  assign a_ext = {1'b0, smp_q};
  assign b_ext = {1'b0, tcode};
  assign diff  = (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
  assign match = (diff <= TOL_V);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    smp_d   = smp_q;
    chan_d  = chan_q;
    hit_d   = hit_q;
    ridx_d  = ridx_q;
    volt_d  = volt_q;
    power_d = power_q;
    rchan_d = rchan_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.smp_valid) begin
          smp_d   = bus.smp_data;
          chan_d  = bus.smp_chan;
          idx_d   = 3'(N_ENTRIES - 1);
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (match) begin
          hit_d   = 1'b1;
          ridx_d  = idx_q;
          volt_d  = tvolt;
          power_d = tpower;
          rchan_d = chan_q;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = HOLD;
        end else if (idx_q != 3'd0) begin
          idx_d = idx_q - 3'd1;
        end else begin
          hit_d   = 1'b0;
          ridx_d  = '0;
          volt_d  = '0;
          power_d = '0;
          rchan_d = chan_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      smp_q   <= '0;
      chan_q  <= '0;
      hit_q   <= 1'b0;
      ridx_q  <= '0;
      volt_q  <= '0;
      power_q <= '0;
      rchan_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      smp_q   <= smp_d;
      chan_q  <= chan_d;
      hit_q   <= hit_d;
      ridx_q  <= ridx_d;
      volt_q  <= volt_d;
      power_q <= power_d;
      rchan_q <= rchan_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.smp_ready = (state_q == IDLE);
  assign bus.res_valid = (state_q == HOLD);
  assign bus.res_hit   = hit_q;
  assign bus.res_idx   = ridx_q;
  assign bus.res_volt  = volt_q;
  assign bus.res_power = power_q;
  assign bus.res_chan  = rchan_q;
  assign hit_count     = cnt_q;

endmodule

// File: tb/tb_adc_code_matcher.sv
// Directed bench for adc_code_matcher: exact-match and tolerance instances against a table-search model.
module tb_adc_code_matcher;

  localparam int NE = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cnt0, cnt1;

  adc_code_matcher_if #(.DW(10)) if0 ();
  adc_code_matcher_if #(.DW(10)) if1 ();

  adc_code_matcher #(.N_ENTRIES(5), .DW(10), .TOL(0), .CNT_W(16)) dut0 (
    .fpga_clk(clk), .rst_n(rst_n), .bus(if0.slave), .hit_count(cnt0)
  );
  adc_code_matcher #(.N_ENTRIES(5), .DW(10), .TOL(4), .CNT_W(16)) dut1 (
    .fpga_clk(clk), .rst_n(rst_n), .bus(if1.slave), .hit_count(cnt1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int mc [2][NE];
  int mv [2][NE];
  int mp [2][NE];
  int tol [2] = '{0, 4};
  int ecnt [2];
  int ehit [2], eidx [2], evolt [2], epow [2], echan [2];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_model();
    int dc [NE] = '{1023, 819, 614, 409, 204};
    int dv [NE] = '{5, 4, 3, 2, 1};
    int dp [NE] = '{45, 50, 75, 80, 20};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NE; i++) begin
        mc[k][i] = dc[i];
        mv[k][i] = dv[i];
        mp[k][i] = dp[i];
      end
      ecnt[k] = 0;
    end
  endtask

  // First entry from the top index whose code lies within the tolerance wins.
  task automatic model(input int inst, input int s, output int hit, output int idx,
                       output int volt, output int power);
    hit = 0; idx = 0; volt = 0; power = 0;
    for (int i = NE - 1; i >= 0; i--) begin
      int d;
      d = (s > mc[inst][i]) ? s - mc[inst][i] : mc[inst][i] - s;
      if (d <= tol[inst]) begin
        hit = 1; idx = i; volt = mv[inst][i]; power = mp[inst][i];
        return;
      end
    end
  endtask

  task automatic drive_smp(input int inst, input bit v, input int d, input int c);
    if (inst == 0) begin
      if0.smp_valid = v; if0.smp_data = 10'(d); if0.smp_chan = 3'(c);
    end else begin
      if1.smp_valid = v; if1.smp_data = 10'(d); if1.smp_chan = 3'(c);
    end
  endtask

  task automatic drive_rr(input int inst, input bit r);
    if (inst == 0) if0.res_ready = r;
    else           if1.res_ready = r;
  endtask

  function automatic int rd_ready(input int inst);
    return (inst == 0) ? int'(if0.smp_ready) : int'(if1.smp_ready);
  endfunction

  function automatic int rd_valid(input int inst);
    return (inst == 0) ? int'(if0.res_valid) : int'(if1.res_valid);
  endfunction

  task automatic cmp(input int inst, input int hit, input int idx, input int volt,
                     input int power, input int chan, input int cnt);
    check($sformatf("i%0d res_hit", inst), hit, ehit[inst]);
    check($sformatf("i%0d res_idx", inst), idx, eidx[inst]);
    check($sformatf("i%0d res_volt", inst), volt, evolt[inst]);
    check($sformatf("i%0d res_power", inst), power, epow[inst]);
    check($sformatf("i%0d res_chan", inst), chan, echan[inst]);
    check($sformatf("i%0d hit_count", inst), cnt, ecnt[inst]);
  endtask

  // Every cycle a result is presented it must equal the model's answer for the accepted sample.
  always @(negedge clk) begin
    if (if0.res_valid)
      cmp(0, int'(if0.res_hit), int'(if0.res_idx), int'(if0.res_volt),
          int'(if0.res_power), int'(if0.res_chan), int'(cnt0));
    if (if1.res_valid)
      cmp(1, int'(if1.res_hit), int'(if1.res_idx), int'(if1.res_volt),
          int'(if1.res_power), int'(if1.res_chan), int'(cnt1));
  end

  task automatic accept_and_wait(input int inst, input int d, input int c);
    int h, ix, v, p, k;
    check($sformatf("i%0d smp_ready before accept", inst), rd_ready(inst), 1);
    model(inst, d, h, ix, v, p);
    ehit[inst] = h; eidx[inst] = ix; evolt[inst] = v; epow[inst] = p; echan[inst] = c;
    if (h != 0 && ecnt[inst] < 65535) ecnt[inst]++;
    drive_smp(inst, 1'b1, d, c);
    @(posedge clk);
    @(negedge clk);
    drive_smp(inst, 1'b0, d, c);
    k = 0;
    while (rd_valid(inst) == 0 && k < 12) begin
      check($sformatf("i%0d smp_ready in search", inst), rd_ready(inst), 0);
      @(negedge clk);
      k++;
    end
    check($sformatf("i%0d latency s=%0d", inst, d), k, (h != 0) ? NE - ix : NE);
  endtask

  task automatic release_res(input int inst);
    drive_rr(inst, 1'b1);
    @(negedge clk);
    drive_rr(inst, 1'b0);
    check($sformatf("i%0d res_valid after take", inst), rd_valid(inst), 0);
    check($sformatf("i%0d smp_ready after take", inst), rd_ready(inst), 1);
  endtask

  task automatic tbl_write(input int a, input int cd, input int v, input int p);
    if0.tbl_we = 1'b1; if0.tbl_addr = 3'(a);
    if0.tbl_code = 10'(cd); if0.tbl_volt = 10'(v); if0.tbl_power = 10'(p);
    @(negedge clk);
    if0.tbl_we = 1'b0;
    if (a < NE) begin
      mc[0][a] = cd; mv[0][a] = v; mp[0][a] = p;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h, ix, v, p;
    if0.smp_valid = 1'b0; if0.smp_data = '0; if0.smp_chan = '0; if0.res_ready = 1'b0;
    if0.tbl_we = 1'b0; if0.tbl_addr = '0; if0.tbl_code = '0; if0.tbl_volt = '0; if0.tbl_power = '0;
    if1.smp_valid = 1'b0; if1.smp_data = '0; if1.smp_chan = '0; if1.res_ready = 1'b0;
    if1.tbl_we = 1'b0; if1.tbl_addr = '0; if1.tbl_code = '0; if1.tbl_volt = '0; if1.tbl_power = '0;
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset smp_ready", int'(if0.smp_ready), 1);
    check("reset res_valid", int'(if0.res_valid), 0);
    check("reset res_hit", int'(if0.res_hit), 0);
    check("reset res_idx", int'(if0.res_idx), 0);
    check("reset res_volt", int'(if0.res_volt), 0);
    check("reset res_power", int'(if0.res_power), 0);
    check("reset res_chan", int'(if0.res_chan), 0);
    check("reset hit_count", int'(cnt0), 0);

    model(0, 614, h, ix, v, p);
    check("model 614 idx", ix, 2); check("model 614 power", p, 75);
    model(0, 500, h, ix, v, p);
    check("model 500 hit", h, 0);
    model(1, 1020, h, ix, v, p);
    check("model tol 1020 idx", ix, 0); check("model tol 1020 power", p, 45);
    model(1, 1018, h, ix, v, p);
    check("model tol 1018 hit", h, 0);
    model(1, 823, h, ix, v, p);
    check("model tol 823 idx", ix, 1); check("model tol 823 power", p, 50);

    accept_and_wait(0, 614, 2);
    check("614 hit", int'(if0.res_hit), 1);
    check("614 idx", int'(if0.res_idx), 2);
    check("614 volt", int'(if0.res_volt), 3);
    check("614 power", int'(if0.res_power), 75);
    check("614 chan", int'(if0.res_chan), 2);
    check("614 hit_count", int'(cnt0), 1);
    release_res(0);

    accept_and_wait(0, 500, 5);
    check("500 hit", int'(if0.res_hit), 0);
    check("500 power", int'(if0.res_power), 0);
    check("500 chan", int'(if0.res_chan), 5);
    check("500 hit_count", int'(cnt0), 1);
    release_res(0);

    accept_and_wait(1, 1020, 1);
    check("tol 1020 power", int'(if1.res_power), 45);
    release_res(1);
    accept_and_wait(1, 1018, 6);
    check("tol 1018 hit", int'(if1.res_hit), 0);
    release_res(1);
    accept_and_wait(1, 823, 7);
    check("tol 823 idx", int'(if1.res_idx), 1);
    check("tol 823 hit_count", int'(cnt1), 2);
    release_res(1);

    // A new sample waits at the input while the previous result is back-pressured.
    accept_and_wait(0, 409, 3);
    drive_smp(0, 1'b1, 204, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp smp_ready", int'(if0.smp_ready), 0);
      check("bp res_valid", int'(if0.res_valid), 1);
      check("bp res_idx", int'(if0.res_idx), 3);
    end
    release_res(0);
    accept_and_wait(0, 204, 4);
    check("bp second idx", int'(if0.res_idx), 4);
    check("bp second chan", int'(if0.res_chan), 4);
    release_res(0);

    tbl_write(1, 100, 7, 99);
    accept_and_wait(0, 100, 0);
    check("wr idx", int'(if0.res_idx), 1);
    check("wr volt", int'(if0.res_volt), 7);
    check("wr power", int'(if0.res_power), 99);
    release_res(0);
    tbl_write(6, 614, 9, 9);
    accept_and_wait(0, 614, 2);
    check("oob write power", int'(if0.res_power), 75);
    release_res(0);

    drive_smp(0, 1'b1, 500, 1);
    @(posedge clk);
    @(negedge clk);
    drive_smp(0, 1'b0, 500, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset res_valid", int'(if0.res_valid), 0);
    check("midreset smp_ready", int'(if0.smp_ready), 1);
    check("midreset hit_count", int'(cnt0), 0);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept_and_wait(0, 819, 3);
    check("restored idx", int'(if0.res_idx), 1);
    check("restored volt", int'(if0.res_volt), 4);
    check("restored power", int'(if0.res_power), 50);
    check("restored hit_count", int'(cnt0), 1);
    release_res(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
